// File: rtl/hazard_if.sv
// Pipeline-to-hazard-unit bundle: D/E/M/W hazard inputs plus forwarding and stall/flush outputs.
// Build with HAZARD_PERF_EN to carry the StallCycles/FlushCycles performance counters.
interface hazard_if #(
    parameter int RW      = 4,
    parameter int NUM_SRC = 3,
    parameter int CW      = 3
);
    logic                    ValidD;
    logic [NUM_SRC*RW-1:0]   SrcD;
    logic [NUM_SRC-1:0]      SrcValidD;
    logic [RW-1:0]           DstD;
    logic                    RegWriteD;
    logic [CW-1:0]           LatD;
    logic [NUM_SRC*RW-1:0]   SrcE;
    logic [RW-1:0]           DstM;
    logic                    RegWriteM;
    logic [RW-1:0]           DstW;
    logic                    RegWriteW;
    logic                    BranchTakenE;
    logic                    PCWrPendingF;
    logic                    PCSrcW;
    logic [2*NUM_SRC-1:0]    ForwardE;
    logic                    StallF;
    logic                    StallD;
    logic                    FlushD;
    logic                    FlushE;
`ifdef HAZARD_PERF_EN
    logic [31:0]             StallCycles;
    logic [31:0]             FlushCycles;

    modport master (
        output ValidD, SrcD, SrcValidD, DstD, RegWriteD, LatD,
        output SrcE, DstM, RegWriteM, DstW, RegWriteW,
        output BranchTakenE, PCWrPendingF, PCSrcW,
        input  ForwardE, StallF, StallD, FlushD, FlushE,
        input  StallCycles, FlushCycles
    );
    modport slave (
        input  ValidD, SrcD, SrcValidD, DstD, RegWriteD, LatD,
        input  SrcE, DstM, RegWriteM, DstW, RegWriteW,
        input  BranchTakenE, PCWrPendingF, PCSrcW,
        output ForwardE, StallF, StallD, FlushD, FlushE,
        output StallCycles, FlushCycles
    );
`else
    modport master (
        output ValidD, SrcD, SrcValidD, DstD, RegWriteD, LatD,
        output SrcE, DstM, RegWriteM, DstW, RegWriteW,
        output BranchTakenE, PCWrPendingF, PCSrcW,
        input  ForwardE, StallF, StallD, FlushD, FlushE
    );
    modport slave (
        input  ValidD, SrcD, SrcValidD, DstD, RegWriteD, LatD,
        input  SrcE, DstM, RegWriteM, DstW, RegWriteW,
        input  BranchTakenE, PCWrPendingF, PCSrcW,
        output ForwardE, StallF, StallD, FlushD, FlushE
    );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit with per-register pending-latency scoreboard and address-compare forwarding.
// Optional HAZARD_PERF_EN adds saturating StallCycles/FlushCycles counters.

// One pending-latency counter; counts down to zero and is only ever raised by an issue.
module hazard_pend_cell #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set,
    input  logic [CW-1:0] lat,
    output logic [CW-1:0] pend
);
    logic [CW-1:0] dec;

    assign dec = (pend == '0) ? '0 : pend - CW'(1);

    // max(dec, lat) keeps an older, longer write from being shortened by a younger one
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend <= '0;
        else if (set && (lat > dec))
            pend <= lat;
        else
            pend <= dec;
    end
endmodule

// Forwarding select for one E-stage operand; M outranks W.
module hazard_fwd_sel #(
    parameter int RW = 4
) (
    input  logic [RW-1:0] src,
    input  logic [RW-1:0] dst_m,
    input  logic          wr_m,
    input  logic [RW-1:0] dst_w,
    input  logic          wr_w,
    output logic [1:0]    sel
);
    always_comb begin
        sel = 2'b00;
        if (wr_m && (src == dst_m))
            sel = 2'b10;
        else if (wr_w && (src == dst_w))
            sel = 2'b01;
    end
endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int RW       = 4,
    parameter int NUM_SRC  = 3,
    parameter int CW       = 3
) (
    input logic     clk,
    input logic     reset,
    hazard_if.slave hz
);
    logic [NUM_REGS-1:0][CW-1:0] pend;
    logic [NUM_REGS-1:0]         busy;
    logic [NUM_REGS-1:0]         set;
    logic [NUM_SRC-1:0][RW-1:0]  src_d;
    logic [NUM_SRC-1:0][RW-1:0]  src_e;
    logic [NUM_SRC-1:0][1:0]     fwd;
    logic [NUM_SRC-1:0]          src_hit;
    logic                        scb_stall;
    logic                        issue;

    assign src_d = hz.SrcD;
    assign src_e = hz.SrcE;

    // Registers at or above NUM_REGS have no cell, so they never stall and are never set
    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_reg
            assign set[r]  = issue && (hz.DstD == RW'(r));
            assign busy[r] = |pend[r];
            hazard_pend_cell #(.CW(CW)) u_cell (
                .clk   (clk),
                .reset (reset),
                .set   (set[r]),
                .lat   (hz.LatD),
                .pend  (pend[r])
            );
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            hazard_fwd_sel #(.RW(RW)) u_fwd (
                .src   (src_e[i]),
                .dst_m (hz.DstM),
                .wr_m  (hz.RegWriteM),
                .dst_w (hz.DstW),
                .wr_w  (hz.RegWriteW),
                .sel   (fwd[i])
            );
        end
    endgenerate

    assign hz.ForwardE = fwd;

    // Pre-update counters: a self-dependent source sees the old value, not its own issue
    always_comb begin
        src_hit = '0;
        for (int s = 0; s < NUM_SRC; s++)
            for (int k = 0; k < NUM_REGS; k++)
                if (hz.SrcValidD[s] && busy[k] && (src_d[s] == RW'(k)))
                    src_hit[s] = 1'b1;
    end

    assign scb_stall  = hz.ValidD & (|src_hit);
    assign hz.StallD  = scb_stall;
    assign hz.StallF  = scb_stall | hz.PCWrPendingF;
    assign hz.FlushE  = scb_stall | hz.BranchTakenE;
    assign hz.FlushD  = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
    assign issue      = hz.ValidD & hz.RegWriteD & ~hz.StallD & ~hz.FlushE;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hz.StallCycles <= '0;
            hz.FlushCycles <= '0;
        end else begin
            if (hz.StallD && (hz.StallCycles != 32'hFFFF_FFFF))
                hz.StallCycles <= hz.StallCycles + 32'd1;
            if (hz.BranchTakenE && (hz.FlushCycles != 32'hFFFF_FFFF))
                hz.FlushCycles <= hz.FlushCycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for forwarding/flush rules, sequences for the scoreboard.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    hazard_if #(.RW(4), .NUM_SRC(3), .CW(3)) hz ();

    hazard_scoreboard #(.NUM_REGS(16), .RW(4), .NUM_SRC(3), .CW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] src_e;
        logic [3:0]  dst_m;
        logic        wr_m;
        logic [3:0]  dst_w;
        logic        wr_w;
        logic        br;
        logic        pcwp;
        logic        pcsrc;
        logic [5:0]  fwd;
        logic [3:0]  ctl;   // {StallF, StallD, FlushD, FlushE}
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        hz.ValidD    = 1'b0;
        hz.RegWriteD = 1'b0;
        hz.SrcD      = '0;
        hz.SrcValidD = '0;
        hz.DstD      = '0;
        hz.LatD      = '0;
    endtask

    task automatic clear_all();
        clear_d();
        hz.SrcE         = '0;
        hz.DstM         = '0;
        hz.RegWriteM    = 1'b0;
        hz.DstW         = '0;
        hz.RegWriteW    = 1'b0;
        hz.BranchTakenE = 1'b0;
        hz.PCWrPendingF = 1'b0;
        hz.PCSrcW       = 1'b0;
    endtask

    task automatic issue(input logic [3:0] dst, input logic [2:0] lat);
        clear_d();
        hz.ValidD    = 1'b1;
        hz.RegWriteD = 1'b1;
        hz.DstD      = dst;
        hz.LatD      = lat;
        tick();
        clear_d();
    endtask

    // Hold a dependent instruction in D and count how many cycles it stalls
    task automatic count_stall(input int op, input logic [3:0] rsrc, output int n);
        clear_d();
        hz.ValidD          = 1'b1;
        hz.SrcD[op*4 +: 4] = rsrc;
        hz.SrcValidD[op]   = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (!hz.StallD) break;
            n++;
            tick();
        end
        tick();
        clear_d();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
`ifdef HAZARD_PERF_EN
        logic [31:0] perf0;
`endif
        vt[0] = '{12'h000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 4'b0000};
        vt[1] = '{12'h044, 4'd4, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001010, 4'b0000};
        vt[2] = '{12'h044, 4'd4, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000101, 4'b0000};
        vt[3] = '{12'h321, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100001, 4'b0000};
        vt[4] = '{12'h005, 4'd5, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 4'b0000};
        vt[5] = '{12'h777, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101010, 4'b0000};
        vt[6] = '{12'h000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 4'b0011};
        vt[7] = '{12'h000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 4'b1010};
        vt[8] = '{12'h000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 4'b0010};
        vt[9] = '{12'h000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000000, 4'b1011};

        clear_all();
        reset = 1'b1;
        tick();
        check("reset_fwd", 32'(hz.ForwardE), 32'd0);
        check("reset_ctl", 32'({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Combinational forwarding and control rules with no scoreboard activity
        for (int v = 0; v < 10; v++) begin
            clear_all();
            hz.SrcE         = vt[v].src_e;
            hz.DstM         = vt[v].dst_m;
            hz.RegWriteM    = vt[v].wr_m;
            hz.DstW         = vt[v].dst_w;
            hz.RegWriteW    = vt[v].wr_w;
            hz.BranchTakenE = vt[v].br;
            hz.PCWrPendingF = vt[v].pcwp;
            hz.PCSrcW       = vt[v].pcsrc;
            #1;
            check($sformatf("vec%0d_fwd", v), 32'(hz.ForwardE), 32'(vt[v].fwd));
            check($sformatf("vec%0d_ctl", v),
                  32'({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}), 32'(vt[v].ctl));
            tick();
        end
        clear_all();

        // Reset mid-operation clears pending stall asynchronously
        issue(4'd3, 3'd5);
        hz.ValidD       = 1'b1;
        hz.SrcD[3:0]    = 4'd3;
        hz.SrcValidD[0] = 1'b1;
        #1;
        check("pre_reset_stall", 32'(hz.StallD), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_stall", 32'(hz.StallD), 32'd0);
        check("async_reset_fwd", 32'(hz.ForwardE), 32'd0);
        tick();
        check("held_reset_stall", 32'(hz.StallD), 32'd0);
        reset = 1'b0;
        tick();
        check("post_reset_stall", 32'(hz.StallD), 32'd0);
        clear_all();
        tick();

        // ALU result: no stall, forwarded from M
        issue(4'd2, 3'd0);
        hz.ValidD       = 1'b1;
        hz.SrcD[3:0]    = 4'd2;
        hz.SrcValidD[0] = 1'b1;
        hz.SrcE[3:0]    = 4'd2;
        hz.DstM         = 4'd2;
        hz.RegWriteM    = 1'b1;
        #1;
        check("alu_stall", 32'(hz.StallD), 32'd0);
        check("alu_fwd_a", 32'(hz.ForwardE[1:0]), 32'b10);
        tick();
        clear_all();

        // Load-use: exactly one stall cycle
        issue(4'd5, 3'd1);
        hz.ValidD       = 1'b1;
        hz.SrcD[7:4]    = 4'd5;
        hz.SrcValidD[1] = 1'b1;
        #1;
        check("ldr_stall_ctl", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'b111);
        tick();
        check("ldr_stall_done", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'b000);
        tick();
        clear_all();

        // Multi-cycle op: four stall cycles
`ifdef HAZARD_PERF_EN
        perf0 = hz.StallCycles;
`endif
        issue(4'd7, 3'd4);
        count_stall(2, 4'd7, n);
        check("mul_stall_cycles", 32'(n), 32'd4);
`ifdef HAZARD_PERF_EN
        check("perf_stall_delta", hz.StallCycles - perf0, 32'd4);
`endif

        // Younger short write does not shorten older long write (pend 3 -> max(2,1) = 2)
        issue(4'd7, 3'd4);
        tick();
        issue(4'd7, 3'd1);
        count_stall(0, 4'd7, n);
        check("no_shorten_cycles", 32'(n), 32'd2);

        // Self-dependency reads the old counter and still issues
        clear_d();
        hz.ValidD       = 1'b1;
        hz.RegWriteD    = 1'b1;
        hz.DstD         = 4'd6;
        hz.LatD         = 3'd2;
        hz.SrcD[3:0]    = 4'd6;
        hz.SrcValidD[0] = 1'b1;
        #1;
        check("self_dep_stall", 32'(hz.StallD), 32'd0);
        tick();
        count_stall(1, 4'd6, n);
        check("self_dep_cycles", 32'(n), 32'd2);

        // Maximum latency
        issue(4'd1, 3'd7);
        count_stall(0, 4'd1, n);
        check("max_lat_cycles", 32'(n), 32'd7);

        // Taken branch flushes D and suppresses the counter set
`ifdef HAZARD_PERF_EN
        perf0 = hz.FlushCycles;
`endif
        clear_d();
        hz.ValidD       = 1'b1;
        hz.RegWriteD    = 1'b1;
        hz.DstD         = 4'd9;
        hz.LatD         = 3'd3;
        hz.BranchTakenE = 1'b1;
        #1;
        check("branch_flush", 32'({hz.FlushD, hz.FlushE}), 32'b11);
        tick();
        hz.BranchTakenE = 1'b0;
        count_stall(0, 4'd9, n);
        check("branch_no_set", 32'(n), 32'd0);
`ifdef HAZARD_PERF_EN
        check("perf_flush_delta", hz.FlushCycles - perf0, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the core's hazard unit; sits beside the decode/execute pipeline registers.
- Computes forwarding selects for NUM_SRC execute-stage operands by comparing register addresses directly, rather than taking precomputed match bits.
- Replaces the single load-use check with a per-register pending-latency scoreboard, so loads and multi-cycle ops of any latency up to 2^CW-1 stall exactly as long as needed.
- Produces StallF/StallD/FlushD/FlushE with the same control-hazard rules as before.

Parameters:
- NUM_REGS, 16: architectural registers tracked.
- RW, 4: register address width, with NUM_REGS <= 2^RW.
- NUM_SRC, 3: source operands per instruction (A, B, C).
- CW, 3: pending-counter width; maximum latency is 2^CW-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ValidD  in  1  valid instruction in D
- SrcD  in  NUM_SRC*RW  D-stage source addresses; operand i is at [i*RW +: RW]
- SrcValidD  in  NUM_SRC  source i is actually read
- DstD  in  RW  D-stage destination
- RegWriteD  in  1  D instruction writes DstD
- LatD  in  CW  extra cycles before the result can be forwarded (ALU=0, LDR=1, MUL=k)
- SrcE  in  NUM_SRC*RW  E-stage source addresses
- DstM  in  RW  M-stage destination
- RegWriteM  in  1  M-stage register write
- DstW  in  RW  W-stage destination
- RegWriteW  in  1  W-stage register write
- BranchTakenE  in  1  branch resolved taken in E
- PCWrPendingF  in  1  PC write in flight
- PCSrcW  in  1  PC written in W
- ForwardE  out  2*NUM_SRC  per operand: 10=M, 01=W, 00=register file
- StallF  out  1  stall fetch
- StallD  out  1  stall decode
- FlushD  out  1  flush decode
- FlushE  out  1  flush execute

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state: all pending counters pend[r] = 0. All outputs then evaluate to 0, given zero inputs.
- Forwarding (combinational), per operand i:
  - 10 if RegWriteM and SrcE_i == DstM;
  - else 01 if RegWriteW and SrcE_i == DstW;
  - else 00.
  - M has priority over W.
- Scoreboard stall (combinational): scbStallD = ValidD & OR over i of (SrcValidD[i] & pend[SrcD_i] != 0). The check uses pre-update counter values.
- Stall/flush equations:
  - StallD = scbStallD
  - StallF = scbStallD | PCWrPendingF
  - FlushE = scbStallD | BranchTakenE
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
- Issue: IssueD = ValidD & RegWriteD & ~StallD & ~FlushE.
- Counter update (posedge clk), for every r:
  - Base value: next = (pend[r] == 0) ? 0 : pend[r] - 1.
  - If IssueD and r == DstD: pend[r] <= max(next, LatD). A younger write never shortens an older in-flight write.
  - Otherwise: pend[r] <= next.
- Resulting latency:
  - LatD=0: the dependent instruction is never stalled.
  - LatD=1: exactly 1 stall cycle (load-use).
  - LatD=k: k stall cycles for an immediately dependent instruction.
- Self-dependency: a source equal to its own DstD sees the old counter value, not the one being issued.
- Branch taken in the same cycle as issue: the D instruction is flushed and does not set its counter.
- Reset asserted mid-operation: all counters clear immediately (asynchronously); pending stalls drop.
- Addresses >= NUM_REGS: ignored on issue; they read as pend=0.
- Width rule: LatD is unsigned CW bits; counters saturate at 0 and never wrap.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, add output StallCycles [31:0] and output FlushCycles [31:0].
  - StallCycles increments each cycle StallD=1; FlushCycles increments each cycle BranchTakenE=1.
  - Both saturate at 32'hFFFF_FFFF and reset asynchronously to 0.
- When undefined, neither port nor either counter exists.

Test Plan:
- Reset asserted with pend[3] nonzero -> all counters 0 immediately; ForwardE=0; StallD=0 while reset is held.
- Issue DstD=2, LatD=0, RegWriteD=1; next cycle SrcD_0=2 valid -> StallD=0. With SrcE_0=2, DstM=2, RegWriteM=1 -> ForwardE[1:0]=10.
- Load-use: issue DstD=5, LatD=1; next cycle SrcD_1=5 -> StallD=StallF=FlushE=1 for exactly 1 cycle, then 0.
- Multiply: issue DstD=7, LatD=4; dependent SrcD_2=7 follows -> StallD=1 for 4 consecutive cycles. Issuing DstD=7, LatD=1 while pend[7]=3 -> next pend[7]=2, not 1.
- Forwarding priority: SrcE_0=SrcE_1=4, DstM=DstW=4, RegWriteM=RegWriteW=1 -> ForwardE=0b001010 (operand C 00). Drop RegWriteM -> 0b000101.
- BranchTakenE=1 with ValidD, RegWriteD, DstD=9, LatD=3 -> FlushD=FlushE=1 and pend[9] stays 0. With HAZARD_PERF_EN, FlushCycles increments by 1.
